mipi_csi_tx_sched: RTL

- CSI-2 packet scheduler that sequences the MIPI PHY serializer.
- Arbitrates three requesters: frame-start short packet, line long packet and frame-end short packet.
- Builds each packet (header, ECC, payload, CRC16) and drives hs_req/data to the PHY, advancing one byte per cycle while the PHY's read-enable is high.
- Enforces a minimum LP gap between HS bursts.

---
 rtl/mipi_csi_pkg.sv | 14 +
 rtl/mipi_csi_tx_sched_crc16.sv | 23 ++
 rtl/mipi_csi_tx_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: CSI-2 data types, state/packet encodings, CRC constants and header ECC
package mipi_csi_pkg;
  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_RAW8 = 6'h2A;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CRC, S_END, S_GAP} state_e;
  typedef enum logic [1:0] {PK_FS, PK_LN, PK_FE} pkt_e;
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
endpackage

// File: rtl/mipi_csi_tx_sched_crc16.sv
// mipi_csi_crc16: byte-wide reflected CRC-16/CCITT register, built only with MIPI_CSI_TX_CRC_EN
`ifdef MIPI_CSI_TX_CRC_EN
module mipi_csi_crc16
  import mipi_csi_pkg::*;
(
  input  logic        clk_hs,
  input  logic        resetb,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc_q
);
  logic [15:0] crc_nxt, crc_d;
  always_comb begin
    crc_nxt = crc_q ^ {8'h00, data};
    for (int i = 0; i < 8; i++) crc_nxt = crc_nxt[0] ? (crc_nxt >> 1) ^ CRC_POLY : crc_nxt >> 1;
    crc_d = init ? CRC_SEED : en ? crc_nxt : crc_q;
  end
  always_ff @(posedge clk_hs or negedge resetb)
    if (!resetb) crc_q <= CRC_SEED;
    else crc_q <= crc_d;
endmodule
`endif

// File: rtl/mipi_csi_tx_sched.sv
// mipi_csi_tx_sched: CSI-2 FS/line/FE packet scheduler feeding the PHY byte stream (payload CRC under MIPI_CSI_TX_CRC_EN)
module mipi_csi_tx_sched
  import mipi_csi_pkg::*;
#(
  parameter logic [1:0]  VC            = 2'd0,
  parameter int          GAP_CYCLES    = 16,
  parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
  input  logic        clk_hs,
  input  logic        resetb,
  input  logic        enable,
  input  logic        fs_req,
  input  logic        fe_req,
  input  logic        line_req,
  input  logic [5:0]  line_dt,
  input  logic [15:0] line_wc,
  input  logic [7:0]  pix_data,
  input  logic        pix_empty,
  output logic        pix_re,
  output logic        hs_req,
  input  logic        phy_re,
  output logic [7:0]  phy_data,
  output logic        fs_ack,
  output logic        fe_ack,
  output logic        line_ack,
  output logic        busy,
  output logic        underflow
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  state_e st_q, st_d;
  pkt_e kind_q, kind_d;
  logic fs_p_q, fs_p_d, fe_p_q, fe_p_d, ln_p_q, ln_p_d;
  logic [5:0] ldt_q, ldt_d;
  logic [15:0] lwc_q, lwc_d, pkt_wc_q, pkt_wc_d, cnt_q, cnt_d, frame_num_q, frame_num_d;
  logic [7:0] di_q, di_d, phy_data_q, phy_data_d, pay_byte, hdr_byte;
  logic [GW-1:0] gap_q, gap_d;
  logic hs_req_q, hs_req_d, fs_ack_q, fs_ack_d, fe_ack_q, fe_ack_d, line_ack_q, line_ack_d;
  logic underflow_q, underflow_d, grant, g_fs, g_ln;
  logic [15:0] crc;
`ifdef MIPI_CSI_TX_CRC_EN
  mipi_csi_crc16 u_crc (
    .clk_hs (clk_hs),
    .resetb (resetb),
    .init   (grant),
    .en     (st_q == S_PAY && phy_re),
    .data   (pay_byte),
    .crc_q  (crc)
  );
`else
  assign crc = '0;
`endif
  always_comb begin
    grant = st_q == S_IDLE && enable && (fs_p_q || ln_p_q || fe_p_q);
    g_fs = grant && fs_p_q;
    g_ln = grant && !fs_p_q && ln_p_q;
    pay_byte = pix_empty ? 8'h00 : pix_data;
    hdr_byte = cnt_q[1:0] == 2'd0 ? pkt_wc_q[7:0] : cnt_q[1:0] == 2'd1 ? pkt_wc_q[15:8] :
               {2'b00, csi_ecc({pkt_wc_q, di_q})};
    fs_p_d = (fs_p_q || fs_req) && !g_fs;
    ln_p_d = (ln_p_q || line_req) && !g_ln;
    fe_p_d = (fe_p_q || fe_req) && !(grant && !fs_p_q && !ln_p_q);
    ldt_d = line_req && !ln_p_q ? line_dt : ldt_q;
    lwc_d = line_req && !ln_p_q ? line_wc : lwc_q;
    st_d = st_q;
    kind_d = kind_q;
    di_d = di_q;
    pkt_wc_d = pkt_wc_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    frame_num_d = frame_num_q;
    hs_req_d = hs_req_q;
    phy_data_d = phy_data_q;
    fs_ack_d = 1'b0;
    fe_ack_d = 1'b0;
    line_ack_d = 1'b0;
    underflow_d = underflow_q || (st_q == S_PAY && phy_re && pix_empty);
    case (st_q)
      S_IDLE: if (grant) begin
        st_d = S_HDR;
        kind_d = g_fs ? PK_FS : g_ln ? PK_LN : PK_FE;
        di_d = {VC, g_fs ? DT_FS : g_ln ? ldt_q : DT_FE};
        pkt_wc_d = g_ln ? lwc_q : frame_num_q;
        phy_data_d = di_d;
        hs_req_d = 1'b1;
        cnt_d = '0;
      end
      S_HDR: if (phy_re) begin
        cnt_d = cnt_q + 16'd1;
        phy_data_d = hdr_byte;
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d = '0;
          st_d = kind_q != PK_LN ? S_END : pkt_wc_q != 16'd0 ? S_PAY : S_CRC;
          hs_req_d = kind_q == PK_LN;
          fs_ack_d = kind_q == PK_FS;
          fe_ack_d = kind_q == PK_FE;
        end
      end
      S_PAY: if (phy_re) begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == pkt_wc_q - 16'd1) begin
          cnt_d = '0;
          st_d = S_CRC;
        end
      end
      S_CRC: if (phy_re) begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q[0]) begin
          st_d = S_END;
          hs_req_d = 1'b0;
          line_ack_d = 1'b1;
        end
      end
      S_END: begin
        st_d = S_GAP;
        gap_d = GW'(GAP_CYCLES - 1);
        if (kind_q == PK_FE) frame_num_d = frame_num_q == FRAME_NUM_MAX ? 16'd1 : frame_num_q + 16'd1;
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == '0) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_hs or negedge resetb)
    if (!resetb) begin
      st_q <= S_IDLE;
      kind_q <= PK_FS;
      fs_p_q <= 1'b0;
      fe_p_q <= 1'b0;
      ln_p_q <= 1'b0;
      ldt_q <= '0;
      lwc_q <= '0;
      di_q <= '0;
      pkt_wc_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      frame_num_q <= 16'd1;
      hs_req_q <= 1'b0;
      phy_data_q <= '0;
      fs_ack_q <= 1'b0;
      fe_ack_q <= 1'b0;
      line_ack_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      st_q <= st_d;
      kind_q <= kind_d;
      fs_p_q <= fs_p_d;
      fe_p_q <= fe_p_d;
      ln_p_q <= ln_p_d;
      ldt_q <= ldt_d;
      lwc_q <= lwc_d;
      di_q <= di_d;
      pkt_wc_q <= pkt_wc_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      frame_num_q <= frame_num_d;
      hs_req_q <= hs_req_d;
      phy_data_q <= phy_data_d;
      fs_ack_q <= fs_ack_d;
      fe_ack_q <= fe_ack_d;
      line_ack_q <= line_ack_d;
      underflow_q <= underflow_d;
    end
  assign phy_data = st_q == S_PAY ? pay_byte : st_q == S_CRC ? (cnt_q[0] ? crc[15:8] : crc[7:0]) : phy_data_q;
  assign pix_re = st_q == S_PAY && phy_re && !pix_empty;
  assign hs_req = hs_req_q;
  assign fs_ack = fs_ack_q;
  assign fe_ack = fe_ack_q;
  assign line_ack = line_ack_q;
  assign underflow = underflow_q;
  assign busy = st_q != S_IDLE || fs_p_q || fe_p_q || ln_p_q;
endmodule
